// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares one RGB LED between two requesters and plays timed
// OFF / SOLID / BLINK jobs on it. Each job runs reps x (PH_A + PH_B), and each
// phase lasts TICK_DIV clki cycles.
// Optional feature: define RGB_ARB_RR_EN to get round-robin arbitration.
// Without it, requester 0 has fixed priority.
module rgb_led_arbiter #(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic       clki,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_color,
    input  logic [1:0] req0_mode,
    input  logic [3:0] req0_reps,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_color,
    input  logic [1:0] req1_mode,
    input  logic [3:0] req1_reps,
    output logic       busy,
    output logic       owner,
    output logic       rgb0,
    output logic       rgb1,
    output logic       rgb2
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH_A = 2'd1,
        ST_PH_B = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] presc_r;
    logic [2:0]       color_r;
    logic [1:0]       mode_r;
    logic [4:0]       reps_r;
    logic [4:0]       rep_cnt_r;
    logic             owner_r;
    logic             busy_r;
    logic [2:0]       rgb_r;
    logic [2:0]       rgb_nxt_s;
    logic             busy_nxt_s;
    logic             prio_s;
    logic             idle_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             hs_s;
    logic             wrap_s;
    logic             last_rep_s;
    logic [2:0]       sel_color_s;
    logic [1:0]       sel_mode_s;
    logic [4:0]       sel_reps_s;
    logic [2:0]       eff_color_s;
    logic [1:0]       eff_mode_s;

`ifdef RGB_ARB_RR_EN
    logic prio_r;

    // Priority pointer moves to whichever requester lost the last handshake
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (hs_s) begin
            prio_r <= ~grant1_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign prio_s = prio_r;
`else
    assign prio_s = 1'b0;
`endif

    assign wrap_s     = (presc_r == CNT_W'(TICK_DIV - 1));
    assign last_rep_s = (rep_cnt_r == (reps_r - 5'd1));

    // Arbitration: the priority holder is always ready in IDLE; the other side only when the holder is quiet
    always_comb begin
        idle_s     = (state_r == ST_IDLE) && rst_n;
        req0_ready = idle_s && ((prio_s == 1'b0) || !req1_valid);
        req1_ready = idle_s && ((prio_s == 1'b1) || !req0_valid);
        grant0_s   = req0_valid && req0_ready;
        grant1_s   = req1_valid && req1_ready;
        hs_s       = grant0_s || grant1_s;
        if (grant1_s) begin
            sel_color_s = req1_color;
            sel_mode_s  = req1_mode;
            sel_reps_s  = (req1_reps == 4'd0) ? 5'd16 : {1'b0, req1_reps};
        end else begin
            sel_color_s = req0_color;
            sel_mode_s  = req0_mode;
            sel_reps_s  = (req0_reps == 4'd0) ? 5'd16 : {1'b0, req0_reps};
        end
    end

    // FSM state register
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: phases advance on prescaler wrap; the job ends after the last PH_B
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) state_nxt_s = ST_PH_A;
                else      state_nxt_s = ST_IDLE;
            end
            ST_PH_A: begin
                if (wrap_s) state_nxt_s = ST_PH_B;
                else        state_nxt_s = ST_PH_A;
            end
            ST_PH_B: begin
                if (wrap_s && last_rep_s)  state_nxt_s = ST_IDLE;
                else if (wrap_s)           state_nxt_s = ST_PH_A;
                else                       state_nxt_s = ST_PH_B;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: LED value for the state being entered (uses the incoming job on a handshake)
    always_comb begin
        rgb_nxt_s  = 3'b000;
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        if (hs_s) begin
            eff_color_s = sel_color_s;
            eff_mode_s  = sel_mode_s;
        end else begin
            eff_color_s = color_r;
            eff_mode_s  = mode_r;
        end
        case (state_nxt_s)
            ST_PH_A: rgb_nxt_s = (eff_mode_s != 2'd0) ? eff_color_s : 3'b000;
            ST_PH_B: rgb_nxt_s = (eff_mode_s == 2'd1) ? eff_color_s : 3'b000;
            default: rgb_nxt_s = 3'b000;
        endcase
    end

    // Job datapath: latch the job on handshake, run the prescaler and count repetitions
    always_ff @(posedge clki) begin
        if (!rst_n) begin
            presc_r   <= '0;
            color_r   <= 3'b000;
            mode_r    <= 2'd0;
            reps_r    <= 5'd0;
            rep_cnt_r <= 5'd0;
            owner_r   <= 1'b0;
            busy_r    <= 1'b0;
            rgb_r     <= 3'b000;
        end else begin
            busy_r <= busy_nxt_s;
            rgb_r  <= rgb_nxt_s;
            if (hs_s) begin
                presc_r   <= '0;
                color_r   <= sel_color_s;
                mode_r    <= sel_mode_s;
                reps_r    <= sel_reps_s;
                rep_cnt_r <= 5'd0;
                owner_r   <= grant1_s;
            end else if (state_r != ST_IDLE) begin
                presc_r <= wrap_s ? '0 : (presc_r + CNT_W'(1));
                if ((state_r == ST_PH_B) && wrap_s && !last_rep_s) begin
                    rep_cnt_r <= rep_cnt_r + 5'd1;
                end else begin
                    rep_cnt_r <= rep_cnt_r;
                end
            end else begin
                presc_r <= presc_r;
            end
        end
    end

    assign busy  = busy_r;
    assign owner = owner_r;
    assign rgb0  = rgb_r[0];
    assign rgb1  = rgb_r[1];
    assign rgb2  = rgb_r[2];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with TICK_DIV = 4.
// Expected owner order under contention depends on RGB_ARB_RR_EN.
module tb_rgb_led_arbiter;

    logic       clki;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_color;
    logic [1:0] req0_mode;
    logic [3:0] req0_reps;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_color;
    logic [1:0] req1_mode;
    logic [3:0] req1_reps;
    logic       busy, owner, rgb0, rgb1, rgb2;
    int         checks;
    int         errors;
    logic [3:0] own_seq;

    rgb_led_arbiter #(.TICK_DIV(4), .CNT_W(8)) dut (
        .clki       (clki),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_color (req0_color),
        .req0_mode  (req0_mode),
        .req0_reps  (req0_reps),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_color (req1_color),
        .req1_mode  (req1_mode),
        .req1_reps  (req1_reps),
        .busy       (busy),
        .owner      (owner),
        .rgb0       (rgb0),
        .rgb1       (rgb1),
        .rgb2       (rgb2)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic step();
        @(posedge clki);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call right after the handshake edge: checks every cycle of the job and the idle cycle after it
    task automatic run_job(input logic [2:0] a_val, input logic [2:0] b_val,
                           input int reps_eff, input logic own);
        for (int i = 0; i < 8 * reps_eff; i++) begin
            chk("job_rgb", {5'd0, rgb2, rgb1, rgb0}, {5'd0, (((i / 4) % 2) == 0) ? a_val : b_val});
            chk("job_busy", {7'd0, busy}, 8'd1);
            chk("job_owner", {7'd0, owner}, {7'd0, own});
            step();
        end
        chk("end_busy", {7'd0, busy}, 8'd0);
        chk("end_rgb", {5'd0, rgb2, rgb1, rgb0}, 8'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef RGB_ARB_RR_EN
        own_seq = 4'b1010;
`else
        own_seq = 4'b0000;
`endif
        // 1: reset with both valids high
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_color = 3'b101; req0_mode = 2'd2; req0_reps = 4'd2;
        req1_valid = 1'b1; req1_color = 3'b011; req1_mode = 2'd1; req1_reps = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rgb", {5'd0, rgb2, rgb1, rgb0}, 8'd0);
            chk("rst_busy", {7'd0, busy}, 8'd0);
            chk("rst_rdy0", {7'd0, req0_ready}, 8'd0);
            chk("rst_rdy1", {7'd0, req1_ready}, 8'd0);
            chk("rst_owner", {7'd0, owner}, 8'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_rdy0", {7'd0, req0_ready}, 8'd1);
        chk("rel_rdy1", {7'd0, req1_ready}, 8'd0);

        // 2: BLINK 101 reps 2 from requester 0
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b0;
        run_job(3'b101, 3'b000, 2, 1'b0);
        chk("blink_rdy0", {7'd0, req0_ready}, 8'd1);

        // 3: SOLID 011 reps 1, then OFF reps 1, both from requester 1
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        run_job(3'b011, 3'b011, 1, 1'b1);
        req1_mode = 2'd0;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        run_job(3'b000, 3'b000, 1, 1'b1);

        // 4: continuous contention, four BLINK jobs of one rep
        req0_color = 3'b001; req0_mode = 2'd2; req0_reps = 4'd1;
        req1_color = 3'b100; req1_mode = 2'd2; req1_reps = 4'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            run_job(own_seq[j] ? 3'b100 : 3'b001, 3'b000, 1, own_seq[j]);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // 5: reps 0 means 16 repetitions; mode 3 blinks too
        req0_color = 3'b111; req0_mode = 2'd3; req0_reps = 4'd0;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        run_job(3'b111, 3'b000, 16, 1'b0);

        // 6: reset during PH_A of a reps 3 BLINK, then a fresh request
        req1_color = 3'b110; req1_mode = 2'd2; req1_reps = 4'd3;
        req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        step();
        chk("mid_rgb", {5'd0, rgb2, rgb1, rgb0}, 8'h06);
        chk("mid_owner", {7'd0, owner}, 8'd1);
        rst_n = 1'b0;
        step();
        chk("mrst_rgb", {5'd0, rgb2, rgb1, rgb0}, 8'd0);
        chk("mrst_busy", {7'd0, busy}, 8'd0);
        chk("mrst_owner", {7'd0, owner}, 8'd0);
        chk("mrst_rdy0", {7'd0, req0_ready}, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rgb", {5'd0, rgb2, rgb1, rgb0}, 8'd0);
            chk("post_busy", {7'd0, busy}, 8'd0);
        end
        req0_color = 3'b010; req0_mode = 2'd1; req0_reps = 4'd1;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        run_job(3'b010, 3'b010, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
